// File: rtl/hpdl_write_sequencer.sv
// rtl/hpdl_write_sequencer.sv - HPDL-1414 bus sequencer: host writes plus background caret refresh
module hpdl_write_sequencer #(
  parameter int         T_SETUP     = 2,
  parameter int         T_WR        = 3,
  parameter int         T_HOLD      = 1,
  parameter int         REFRESH_DIV = 1200,
  parameter int         ADDR_INVERT = 1,
  parameter logic [6:0] CARET_CHAR  = 7'h5F
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic [3:0] i_req_pos,
  input  logic [6:0] i_req_char,
  input  logic       i_caret_en,
  input  logic [3:0] i_caret_pos,
  input  logic       i_blink,
  output logic [6:0] HPDL_D,
  output logic [1:0] HPDL_A,
  output logic [3:0] HPDL_WR_N,
  output logic       o_busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_STROBE = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  localparam logic [1:0] A_XOR    = (ADDR_INVERT != 0) ? 2'b11 : 2'b00;
  localparam logic [7:0] SETUP_LD = 8'(T_SETUP - 1);
  localparam logic [7:0] WR_LD    = 8'(T_WR - 1);
  localparam logic [7:0] HOLD_LD  = 8'(T_HOLD - 1);

  localparam int            RW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0] RCNT_LAST = RW'(REFRESH_DIV - 1);

  logic [1:0]    state;
  logic [7:0]    cnt;
  logic [6:0]    shadow [16];
  logic [3:0]    ptr;
  logic [1:0]    dev;
  logic          ref_pend;
  logic [RW-1:0] rcnt;

  logic       host_go;
  logic       ref_go;
  logic       refresh_tick;
  logic [6:0] ref_char;

  assign host_go      = (state == S_IDLE) && i_req_valid && o_req_ready;
  assign ref_go       = (state == S_IDLE) && !host_go && ref_pend;
  assign refresh_tick = (rcnt == RCNT_LAST);
  // The caret is an overlay on the refresh path only; the shadow keeps the real character.
  assign ref_char     = (i_caret_en && (ptr == i_caret_pos) && i_blink) ? CARET_CHAR : shadow[ptr];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= S_IDLE;
      cnt         <= 8'd0;
      ptr         <= 4'd0;
      dev         <= 2'd0;
      ref_pend    <= 1'b1;
      rcnt        <= '0;
      HPDL_WR_N   <= 4'hF;
      HPDL_D      <= 7'h20;
      HPDL_A      <= A_XOR;
      o_req_ready <= 1'b0;
      o_busy      <= 1'b0;
      for (int i = 0; i < 16; i++) shadow[i] <= 7'h20;
    end else begin
      rcnt     <= refresh_tick ? '0 : rcnt + 1'b1;
      // A new tick on the serve edge must survive, so set dominates clear.
      ref_pend <= refresh_tick | (ref_pend & ~ref_go);

      case (state)
        S_IDLE: begin
          if (host_go) begin
            shadow[i_req_pos] <= i_req_char;
            HPDL_D      <= i_req_char;
            HPDL_A      <= i_req_pos[1:0] ^ A_XOR;
            dev         <= i_req_pos[3:2];
            state       <= S_SETUP;
            cnt         <= SETUP_LD;
            o_req_ready <= 1'b0;
            o_busy      <= 1'b1;
          end else if (ref_go) begin
            HPDL_D      <= ref_char;
            HPDL_A      <= ptr[1:0] ^ A_XOR;
            dev         <= ptr[3:2];
            ptr         <= ptr + 4'd1;
            state       <= S_SETUP;
            cnt         <= SETUP_LD;
            o_req_ready <= 1'b0;
            o_busy      <= 1'b1;
          end else begin
            o_req_ready <= 1'b1;
            o_busy      <= 1'b0;
          end
        end
        S_SETUP: begin
          if (cnt == 8'd0) begin
            state     <= S_STROBE;
            cnt       <= WR_LD;
            HPDL_WR_N <= ~(4'b0001 << dev);
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_STROBE: begin
          if (cnt == 8'd0) begin
            state     <= S_HOLD;
            cnt       <= HOLD_LD;
            HPDL_WR_N <= 4'hF;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: begin
          if (cnt == 8'd0) begin
            state       <= S_IDLE;
            o_req_ready <= 1'b1;
            o_busy      <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
      endcase
    end
  end

endmodule
